inv_round_sequencer: RTL and testbench
======================================

# inv_round_sequencer

Sequential AES decryption round stage that drives the 32-bit inverse MixColumns column transform (InvMix32). It accepts a 128-bit state and a 128-bit round key, performs AddRoundKey, then streams the four columns through an externally instantiated InvMix32 one per cycle and reassembles the 128-bit result. It sits directly upstream of InvMix32, feeding it, and directly downstream of it, consuming its output. Ready/valid handshakes on both sides let it chain with the InvShiftRows/InvSubBytes stages.

## Interface
- No parameters; widths fixed: state 128, column 32.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  state_in/round_key/skip_mix valid.
- in_ready  out  1  block can accept; high only in IDLE.
- state_in  in  128  ciphertext-side state; column 0 = [127:96], column 3 = [31:0].
- round_key  in  128  round key, same column order.
- skip_mix  in  1  final-round flag: AddRoundKey only, no InvMixColumns.
- mix_col_out  out  32  column to InvMix32 dataIn; byte a0 = [31:24].
- mix_col_in  in  32  InvMix32 dataOut (combinational return).
- out_valid  out  1  state_out valid.
- out_ready  in  1  downstream accepts state_out.
- state_out  out  128  result state, same column order.
- busy  out  1  high in MIX or DONE.

## Operation
- FSM: IDLE, MIX, DONE.
- IDLE: in_ready=1. On in_valid&in_ready: work_reg <= state_in ^ round_key; col_cnt <= 0. Next state is MIX if skip_mix=0; otherwise DONE with state_out <= state_in ^ round_key.
- MIX: mix_col_out = work_reg column col_cnt. Each cycle, state_out column col_cnt <= mix_col_in, col_cnt <= col_cnt+1 (2-bit). When col_cnt==3 captures, go to DONE and col_cnt wraps to 0.
- DONE: out_valid=1 and state_out held stable. On out_ready go to IDLE; out_valid drops the next cycle.
- mix_col_out = 32'h0 outside MIX.
- Inputs are ignored outside IDLE, with no overlap between operations: in_ready=0 in DONE even if out_ready=1.
- All XORs are bitwise; no carries and no width growth.

## Timing
- Reset (rst_n=0 at an edge): FSM=IDLE, col_cnt=0, work_reg=0, state_out=0, out_valid=0, busy=0, mix_col_out=0. in_ready is 1 from the first cycle after reset.
- Reset mid-MIX or mid-DONE: the operation is abandoned, no out_valid, and no partial result is exposed (state_out=0).
- Latency with skip_mix=0: accept edge at T; MIX during cycles T+1..T+4; out_valid high from T+5.
- Latency with skip_mix=1: out_valid high from T+1.
- Throughput: one state per 6 cycles (mix) or 2 cycles (skip) when out_ready is held high.
- Backpressure: DONE holds indefinitely while out_ready=0. state_out must not change while out_valid=1.
- mix_col_in is sampled on the same edge that mix_col_out is presented; the InvMix32 path is combinational within one cycle.
- skip_mix is sampled only at the accept edge.

## Structure
- Shared package aes_dec_pkg: STATE_W=128, COL_W=32, FSM enum {IDLE, MIX, DONE}, and a column-select function (index 0 selects [127:96]).
- InvMix32 is instantiated by the parent, not inside this block. This keeps the block reusable with a shared transform instance.
- No sub-module is needed inside; a single FSM plus datapath.

## Test plan
- Known vector, key 0, skip_mix=0: state_in=8e4da1bc_9fdc589d_01010101_c6c6c6c6 -> state_out=db135345_f20a225c_01010101_c6c6c6c6, with out_valid at accept+5.
- AddRoundKey: state_in=0, round_key=8e4da1bc_9fdc589d_01010101_c6c6c6c6, skip_mix=0 -> same output as the known-vector scenario; mix_col_out sequence 8e4da1bc, 9fdc589d, 01010101, c6c6c6c6.
- Final round: skip_mix=1, state_in=ffff…ff, round_key=0f0f…0f -> state_out=f0f0…f0 at accept+1.
- Backpressure: out_ready=0 for 10 cycles in DONE -> out_valid and state_out stable, in_ready=0; out_ready=1 -> IDLE and in_ready=1 next cycle.
- Reset mid-MIX: assert rst_n=0 at col_cnt=2 -> next cycle all outputs 0, in_ready=1, and no out_valid pulse.
- Back-to-back: two states offered with in_valid held high and out_ready=1 -> second accepted exactly 6 cycles after the first, and both results correct.

Source files
------------

// File: rtl/aes_dec_pkg.sv
// rtl/aes_dec_pkg.sv - shared widths, FSM states and column helpers for AES decrypt stages
package aes_dec_pkg;

    localparam int STATE_W = 128;
    localparam int COL_W   = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MIX  = 2'd1,
        DONE = 2'd2
    } fsm_t;

    // Column 0 is the most significant word of the state.
    function automatic logic [COL_W-1:0] colSel(input logic [STATE_W-1:0] s, input logic [1:0] idx);
        logic [COL_W-1:0] c;
        case (idx)
            2'd0:    c = s[127:96];
            2'd1:    c = s[95:64];
            2'd2:    c = s[63:32];
            default: c = s[31:0];
        endcase
        return c;
    endfunction

    // Returns s with column idx replaced by c.
    function automatic logic [STATE_W-1:0] colPut(input logic [STATE_W-1:0] s, input logic [1:0] idx,
                                                  input logic [COL_W-1:0] c);
        logic [STATE_W-1:0] r;
        r = s;
        case (idx)
            2'd0:    r[127:96] = c;
            2'd1:    r[95:64]  = c;
            2'd2:    r[63:32]  = c;
            default: r[31:0]   = c;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/inv_round_sequencer.sv
// rtl/inv_round_sequencer.sv - AddRoundKey then column-serial InvMixColumns via an external InvMix32
module inv_round_sequencer
    import aes_dec_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [STATE_W-1:0] state_in,
    input  logic [STATE_W-1:0] round_key,
    input  logic               skip_mix,
    output logic [COL_W-1:0]   mix_col_out,
    input  logic [COL_W-1:0]   mix_col_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [STATE_W-1:0] state_out,
    output logic               busy
);

    fsm_t               state;
    fsm_t               stateNext;
    logic [1:0]         colCnt;
    logic [STATE_W-1:0] workReg;
    logic [STATE_W-1:0] resultReg;
    logic               accept;

    assign state_out = resultReg;

    // FSM state register; reset abandons any operation in flight
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state, handshakes and the column presented to InvMix32
    always_comb begin
        stateNext   = state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b0;
        accept      = 1'b0;
        mix_col_out = '0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept    = 1'b1;
                    stateNext = skip_mix ? DONE : MIX;
                end
            end
            MIX: begin
                busy        = 1'b1;
                mix_col_out = colSel(workReg, colCnt);
                if (colCnt == 2'd3) begin
                    stateNext = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // Datapath: key addition on accept, then one returned column per MIX cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            workReg   <= '0;
            resultReg <= '0;
            colCnt    <= 2'd0;
        end else if (accept) begin
            workReg <= state_in ^ round_key;
            colCnt  <= 2'd0;
            if (skip_mix) begin
                resultReg <= state_in ^ round_key;
            end
        end else if (state == MIX) begin
            resultReg <= colPut(resultReg, colCnt, mix_col_in);
            colCnt    <= colCnt + 2'd1;
        end
    end

endmodule

// File: tb/tb_inv_round_sequencer.sv
// tb/tb_inv_round_sequencer.sv - scoreboard bench for inv_round_sequencer with a GF(2^8) reference
module tb_inv_round_sequencer;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] state_in = '0;
    logic [127:0] round_key = '0;
    logic         skip_mix = 1'b0;
    logic [31:0]  mix_col_out;
    logic [31:0]  mix_col_in;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [127:0] state_out;
    logic         busy;

    typedef struct {
        logic [127:0] data;
        int           riseCyc;
    } exp_t;

    exp_t         sbQ[$];
    int           nChecks = 0;
    int           nErr = 0;
    int           cyc = 0;
    logic [127:0] curWork = '0;
    int           colIdx = 0;
    bit           randMode = 0;
    bit           readyReq = 1;
    bit           prevValid = 0;
    bit           prevReady = 0;
    logic [127:0] prevOut = '0;
    int           riseCyc = 0;

    inv_round_sequencer dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .state_in(state_in), .round_key(round_key), .skip_mix(skip_mix),
        .mix_col_out(mix_col_out), .mix_col_in(mix_col_in), .out_valid(out_valid),
        .out_ready(out_ready), .state_out(state_out), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] m);
        logic [7:0] r, p;
        r = 8'h00;
        p = a;
        for (int i = 0; i < 4; i++) begin
            if (m[i]) r = r ^ p;
            p = xt(p);
        end
        return r;
    endfunction

    function automatic logic [31:0] invMixCol(input logic [31:0] c);
        logic [7:0] a[4];
        logic [7:0] b[4];
        for (int i = 0; i < 4; i++) a[i] = c[31-8*i -: 8];
        for (int i = 0; i < 4; i++)
            b[i] = gmul(a[i], 4'he) ^ gmul(a[(i+1)%4], 4'hb) ^ gmul(a[(i+2)%4], 4'hd) ^ gmul(a[(i+3)%4], 4'h9);
        return {b[0], b[1], b[2], b[3]};
    endfunction

    function automatic logic [127:0] model(input logic [127:0] s, input logic [127:0] k, input bit sk);
        logic [127:0] x, r;
        x = s ^ k;
        if (sk) return x;
        for (int j = 0; j < 4; j++) r[127-32*j -: 32] = invMixCol(x[127-32*j -: 32]);
        return r;
    endfunction

    // Stand-in for the parent's combinational InvMix32 instance
    assign mix_col_in = invMixCol(mix_col_out);

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        nChecks++;
        if (act !== req) begin
            nErr++;
            $display("FAIL %s actual=%h required=%h at cycle %0d", name, act, req, cyc);
        end
    endtask

    // out_ready driver: directed level or random toggling
    always @(posedge clk) begin
        #2;
        out_ready = randMode ? 1'($urandom_range(0, 1)) : readyReq;
    end

    // Monitor: column stream, hold behaviour, and scoreboard pops on each transfer
    always @(negedge clk) begin
        if (!rst_n) begin
            prevValid = 0;
        end else begin
            if (!busy) chk("mix_idle_zero", 128'(mix_col_out), 128'h0);
            if (busy && !out_valid) begin
                chk("mix_col_out", 128'(mix_col_out), 128'(curWork[127-32*colIdx -: 32]));
                colIdx = (colIdx + 1) % 4;
            end
            if (out_valid) begin
                if (!prevValid) riseCyc = cyc;
                else chk("hold_state_out", state_out, prevOut);
                chk("in_ready_in_done", 128'(in_ready), 128'h0);
                if (out_ready) begin
                    if (sbQ.size() == 0) begin
                        chk("unexpected_output", 128'(out_valid), 128'h0);
                    end else begin
                        exp_t e;
                        e = sbQ.pop_front();
                        chk("state_out", state_out, e.data);
                        chk("latency", 128'(riseCyc), 128'(e.riseCyc));
                    end
                end
            end else if (prevValid && !prevReady) begin
                chk("valid_dropped", 128'(out_valid), 128'h1);
            end
            prevValid = out_valid;
            prevReady = out_ready;
            prevOut   = state_out;
        end
    end

    // Offer one state; pushes its expected result when the accept is observed
    task automatic offer(input logic [127:0] s, input logic [127:0] k, input bit sk,
                         input logic [127:0] expData, input bit keep, output int accCyc);
        exp_t e;
        bit   ok;
        in_valid  = 1'b1;
        state_in  = s;
        round_key = k;
        skip_mix  = sk;
        ok = 0;
        accCyc = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            chk("accept_timeout", 128'(ok), 128'h1);
        end else begin
            accCyc    = cyc;
            e.data    = expData;
            e.riseCyc = cyc + (sk ? 1 : 5);
            sbQ.push_back(e);
            curWork = s ^ k;
            colIdx  = 0;
        end
        @(posedge clk);
        #1;
        if (!keep) begin
            in_valid = 1'b0;
            state_in = $urandom;
            skip_mix = $urandom_range(0, 1);
        end
    endtask

    task automatic drain();
        bit ok;
        ok = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (sbQ.size() == 0 && !busy) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("drain_timeout", 128'(ok), 128'h1);
        @(posedge clk);
        #1;
    endtask

    localparam logic [127:0] KV_IN  = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam logic [127:0] KV_OUT = 128'hdb135345_f20a225c_01010101_c6c6c6c6;

    initial begin
        int  a1, a2;
        bit  seen;
        logic [127:0] rs, rk;
        bit  rsk;

        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_in_ready", 128'(in_ready), 128'h1);
        chk("reset_out_valid", 128'(out_valid), 128'h0);
        chk("reset_busy", 128'(busy), 128'h0);
        chk("reset_state_out", state_out, 128'h0);
        @(posedge clk);
        #1;

        offer(KV_IN, 128'h0, 1'b0, KV_OUT, 1'b0, a1);
        drain();
        offer(128'h0, KV_IN, 1'b0, KV_OUT, 1'b0, a1);
        drain();
        offer({128{1'b1}}, {16{8'h0f}}, 1'b1, {16{8'hf0}}, 1'b0, a1);
        drain();

        // Backpressure in DONE
        readyReq = 0;
        @(posedge clk);
        #1;
        offer(KV_IN, 128'h1234, 1'b0, model(KV_IN, 128'h1234, 1'b0), 1'b0, a1);
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = out_valid;
        end
        chk("bp_reach_done", 128'(seen), 128'h1);
        in_valid = 1'b1;
        repeat (10) @(negedge clk);
        chk("bp_out_valid", 128'(out_valid), 128'h1);
        chk("bp_in_ready", 128'(in_ready), 128'h0);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        readyReq = 1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_release_in_ready", 128'(in_ready), 128'h1);
        chk("bp_release_out_valid", 128'(out_valid), 128'h0);
        @(posedge clk);
        #1;

        // Reset while column 2 is presented
        offer(KV_IN, 128'h55, 1'b0, model(KV_IN, 128'h55, 1'b0), 1'b0, a1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sbQ.delete();
        @(negedge clk);
        chk("rst_mid_state_out", state_out, 128'h0);
        chk("rst_mid_out_valid", 128'(out_valid), 128'h0);
        chk("rst_mid_busy", 128'(busy), 128'h0);
        chk("rst_mid_mix_col_out", 128'(mix_col_out), 128'h0);
        chk("rst_mid_in_ready", 128'(in_ready), 128'h1);
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        chk("rst_mid_no_valid", 128'(seen), 128'h0);
        @(posedge clk);
        #1;

        // Back-to-back with in_valid held high
        offer(KV_IN, 128'h0, 1'b0, KV_OUT, 1'b1, a1);
        offer(128'h0, KV_IN, 1'b0, KV_OUT, 1'b0, a2);
        chk("b2b_spacing", 128'(a2 - a1), 128'd6);
        drain();

        // Randomised traffic under random backpressure
        randMode = 1;
        for (int n = 0; n < 40; n++) begin
            rs  = {$urandom, $urandom, $urandom, $urandom};
            rk  = {$urandom, $urandom, $urandom, $urandom};
            rsk = 1'($urandom_range(0, 3) == 0);
            offer(rs, rk, rsk, model(rs, rk, rsk), 1'b0, a1);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end
        randMode = 0;
        readyReq = 1;
        drain();
        chk("scoreboard_empty", 128'(sbQ.size()), 128'h0);

        $display("Result: errors=%0d of %0d checks", nErr, nChecks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule
